rnm_inverter_array: RTL and testbench
=====================================

// Module: rnm_inverter_array
// PURPOSE
//  Clocked, multi-channel real-number-model (RNM) inverter/buffer, successor of the single-channel RNM inverter.
//  Per channel: samples a real input each clk, resolves logic level with hysteresis, applies
//  edge-specific propagation delay, then drives a linear real-valued ramp to the new rail.
//  Sits between analog RNM sources and digital/RNM loads in mixed-signal testbenches and top-level models.
// PARAMETERS
//  N_CH     4     number of independent channels
//  VDD      1.8   high rail (V, real)
//  VSS      0.0   low rail (V, real)
//  VTH_HI   1.0   rising input threshold (V); must be >= VTH_LO
//  VTH_LO   0.8   falling input threshold (V)
//  D_PHL    3     output-falling propagation delay, clk cycles (0..255)
//  D_PLH    1     output-rising propagation delay, clk cycles (0..255)
//  N_FALL   4     output fall ramp length, clk cycles (>=1)
//  N_RISE   4     output rise ramp length, clk cycles (>=1)
//  INVERT   1     1 = inverter, 0 = non-inverting buffer
// PORTS
//  clk      in   1          clock; all state updates on posedge
//  rst      in   1          synchronous reset, active-high
//  en       in   N_CH       per-channel enable; 0 freezes that channel's state and vout
//  vin      in   real[N_CH] analog input per channel
//  vout     out  real[N_CH] analog output per channel
//  dout     out  N_CH       resolved logic level of vout (1 once vout reaches VDD, 0 once VSS)
//  busy     out  N_CH       1 while channel in DELAY or RAMP
// BEHAVIOUR
//  Reset (rst=1 at posedge): in_lvl=0, state=HOLD, cnt=0; vout=INVERT?VDD:VSS, dout=INVERT, busy=0.
//  Input resolve per cycle: in_lvl<=1 if vin>=VTH_HI; in_lvl<=0 if vin<VTH_LO; else unchanged.
//  target = in_lvl ^ INVERT. Edge type: target=0 -> fall (D_PHL, N_FALL); target=1 -> rise (D_PLH, N_RISE).
//  States per channel:
//   HOLD : vout at rail. target != dout -> DELAY, cnt=delay of edge. If delay==0 go straight to RAMP.
//   DELAY: cnt-- each cycle, vout unchanged. Inertial: if target reverts to current rail level
//          before cnt reaches 0 -> HOLD, no output change. cnt==0 -> RAMP.
//   RAMP : vout += step each cycle, step=(VDD-VSS)/N_RISE (rise) or -(VDD-VSS)/N_FALL (fall).
//          Clamp to rail; on reaching rail -> HOLD, dout updates same cycle vout hits rail.
//  Latency (no interruption): input crossing registered at cycle 0; vout first moves at cycle
//   1+delay; reaches rail at cycle delay+N; dout toggles same cycle.
//  Reversal during RAMP: new target opposite to ramp direction -> DELAY with the new edge's delay,
//   vout frozen at its intermediate value; then RAMP from that value with the new edge's step, clamped.
//  Reversal during DELAY entered from RAMP: returns to RAMP toward original direction from frozen value.
//  dout changes only on rail arrival; mid-ramp dout holds previous level.
//  en=0: channel state, cnt, vout, dout frozen; in_lvl still tracks vin; on en=1, resumes with current target.
//  Channels fully independent; no shared counters.
//  vin NaN/out-of-range: compared as-is; no clamping of vin.
//  rst mid-DELAY/RAMP: immediate return to reset values at that posedge, pending edge discarded.
//  Floating-point: ramp ends by clamp, not by accumulated equality; tolerance checks use 1e-9 V.
// TESTING
//  T1 reset: rst=1 two cycles, vin=0.0 -> vout=1.8, dout=1, busy=0 all channels.
//  T2 rise of vin 0.0->1.8 ch0 (defaults) -> vout holds 3 cycles, steps 1.35,0.9,0.45,0.0; dout=0 at cycle 7.
//  T3 fall of vin 1.8->0.0 -> vout moves after 1 cycle, 0.45..1.8 over 4 cycles; dout=1 at cycle 5.
//  T4 hysteresis/glitch: vin 0.0->0.9->0.0 -> no output change; vin 0.0->1.8 for 2 cycles then 0.0 -> suppressed.
//  T5 mid-ramp reversal: reverse vin when vout=0.9 -> vout frozen 1 cycle (D_PLH), then ramps 1.35,1.8; dout stays 1.
//  T6 multi-channel + en/rst: ch1 en=0 during ch0 edge -> ch1 frozen, ch0 nominal; rst during ch0 RAMP -> vout=1.8 next edge.

Source files
------------

// File: rtl/rnm_inverter_array.sv
// Multi-channel real-number-model inverter/buffer: hysteretic input resolve, inertial
// edge-specific delay, then a clamped linear ramp of vout to the new rail.
`timescale 1ns/1ps
module rnm_inverter_array #(
  parameter int unsigned N_CH   = 4,
  parameter real         VDD    = 1.8,
  parameter real         VSS    = 0.0,
  parameter real         VTH_HI = 1.0,
  parameter real         VTH_LO = 0.8,
  parameter int unsigned D_PHL  = 3,
  parameter int unsigned D_PLH  = 1,
  parameter int unsigned N_FALL = 4,
  parameter int unsigned N_RISE = 4,
  parameter bit          INVERT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  real             vin  [N_CH],
  output real             vout [N_CH],
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] busy
);

  // state | meaning
  // HOLD  | vout parked at a rail, dout valid
  // DELAY | propagation delay counting, vout frozen
  // RAMP  | vout stepping toward the target rail
  typedef enum logic [1:0] {HOLD, DELAY, RAMP} state_t;

  localparam real        EPS     = 1.0e-9;
  localparam real        STEP_UP = (VDD - VSS) / real'(N_RISE);
  localparam real        STEP_DN = (VDD - VSS) / real'(N_FALL);
  localparam real        RST_V   = INVERT ? VDD : VSS;
  localparam logic [7:0] DLY_F   = 8'(D_PHL);
  localparam logic [7:0] DLY_R   = 8'(D_PLH);

  state_t          state   [N_CH];
  state_t          state_n [N_CH];
  logic [7:0]      cnt     [N_CH];
  logic [7:0]      cnt_n   [N_CH];
  real             vout_n  [N_CH];
  real             ramp_v  [N_CH];
  logic [N_CH-1:0] in_lvl, in_lvl_n, dout_n, dir, dir_n, from_ramp, from_ramp_n;
  logic [N_CH-1:0] target, hit, take_step;

  assign target = in_lvl ^ {N_CH{INVERT}};

  always_comb begin
    in_lvl_n = in_lvl;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (vin[i] >= VTH_HI)     in_lvl_n[i] = 1'b1;
      else if (vin[i] < VTH_LO) in_lvl_n[i] = 1'b0;
    end
  end

  // Candidate next ramp value toward the current target; rail arrival uses a tolerance.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      ramp_v[i] = target[i] ? vout[i] + STEP_UP : vout[i] - STEP_DN;
      hit[i]    = target[i] ? (ramp_v[i] >= VDD - EPS) : (ramp_v[i] <= VSS + EPS);
    end
  end

  always_comb begin
    dout_n      = dout;
    dir_n       = dir;
    from_ramp_n = from_ramp;
    take_step   = '0;
    busy        = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      vout_n[i]  = vout[i];
      busy[i]    = (state[i] != HOLD);
      if (en[i]) begin
        case (state[i])
          HOLD: begin
            if (target[i] != dout[i]) begin
              dir_n[i]       = target[i];
              from_ramp_n[i] = 1'b0;
              cnt_n[i]       = target[i] ? DLY_R : DLY_F;
              if (cnt_n[i] == 8'd0) take_step[i] = 1'b1;
              else                  state_n[i]   = DELAY;
            end
          end
          DELAY: begin
            if (target[i] != dir[i]) begin
              // Inertial cancel: back to the ramp we interrupted, or back to rest.
              dir_n[i]       = target[i];
              from_ramp_n[i] = 1'b0;
              state_n[i]     = from_ramp[i] ? RAMP : HOLD;
            end else if (cnt[i] <= 8'd1) begin
              take_step[i] = 1'b1;
            end else begin
              cnt_n[i] = cnt[i] - 8'd1;
            end
          end
          RAMP: begin
            if (target[i] != dir[i]) begin
              dir_n[i]       = target[i];
              from_ramp_n[i] = 1'b1;
              cnt_n[i]       = target[i] ? DLY_R : DLY_F;
              if (cnt_n[i] == 8'd0) take_step[i] = 1'b1;
              else                  state_n[i]   = DELAY;
            end else begin
              take_step[i] = 1'b1;
            end
          end
          default: state_n[i] = HOLD;
        endcase
        if (take_step[i]) begin
          if (hit[i]) begin
            vout_n[i]      = target[i] ? VDD : VSS;
            state_n[i]     = HOLD;
            dout_n[i]      = target[i];
            from_ramp_n[i] = 1'b0;
          end else begin
            vout_n[i]  = ramp_v[i];
            state_n[i] = RAMP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_lvl    <= '0;
      dout      <= {N_CH{INVERT}};
      dir       <= {N_CH{INVERT}};
      from_ramp <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        state[i] <= HOLD;
        cnt[i]   <= 8'd0;
        vout[i]  <= RST_V;
      end
    end else begin
      in_lvl    <= in_lvl_n;
      dout      <= dout_n;
      dir       <= dir_n;
      from_ramp <= from_ramp_n;
      for (int i = 0; i < int'(N_CH); i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
        vout[i]  <= vout_n[i];
      end
    end
  end

endmodule

// File: tb/tb_rnm_inverter_array.sv
// Directed bench for rnm_inverter_array with default parameters (inverter, D_PHL=3, D_PLH=1, N=4).
`timescale 1ns/1ps
module tb_rnm_inverter_array;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en;
  real          vin  [N];
  real          vout [N];
  logic [N-1:0] dout;
  logic [N-1:0] busy;

  int tests_run    = 0;
  int tests_failed = 0;

  rnm_inverter_array dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .vin  (vin),
    .vout (vout),
    .dout (dout),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic real absd(input real a, input real b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    en  = '1;
    for (int c = 0; c < N; c++) vin[c] = 0.0;
    tick();
    tick();
    for (int c = 0; c < N; c++) begin
      tests_run++;
      if (absd(vout[c], 1.8) > 1e-9) begin
        tests_failed++;
        $display("FAIL reset_vout ch%0d got %f want 1.8", c, vout[c]);
      end
      tests_run++;
      if (dout[c] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_dout ch%0d got %b want 1", c, dout[c]);
      end
      tests_run++;
      if (busy[c] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_busy ch%0d got %b want 0", c, busy[c]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rise;
    real        ev [9];
    logic [8:0] ed, eb;
    ev = '{1.8, 1.8, 1.8, 1.8, 1.35, 0.9, 0.45, 0.0, 0.0};
    ed = 9'b001111111;
    eb = 9'b001111110;
    vin[0] = 1.8;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (absd(vout[0], ev[k]) > 1e-9 || dout[0] !== ed[k] || busy[0] !== eb[k]) begin
        tests_failed++;
        $display("FAIL rise k=%0d got vout=%f dout=%b busy=%b want vout=%f dout=%b busy=%b",
                 k, vout[0], dout[0], busy[0], ev[k], ed[k], eb[k]);
      end
    end
  endtask

  task automatic test_fall;
    real        ev [6];
    logic [5:0] ed, eb;
    ev = '{0.0, 0.0, 0.45, 0.9, 1.35, 1.8};
    ed = 6'b100000;
    eb = 6'b011110;
    vin[0] = 0.0;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests_run++;
      if (absd(vout[0], ev[k]) > 1e-9 || dout[0] !== ed[k] || busy[0] !== eb[k]) begin
        tests_failed++;
        $display("FAIL fall k=%0d got vout=%f dout=%b busy=%b want vout=%f dout=%b busy=%b",
                 k, vout[0], dout[0], busy[0], ev[k], ed[k], eb[k]);
      end
    end
  endtask

  task automatic test_glitch;
    logic [7:0] eb;
    // Input inside the hysteresis band must not resolve high.
    vin[0] = 0.9;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (absd(vout[0], 1.8) > 1e-9 || busy[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL hyst k=%0d got vout=%f busy=%b want vout=1.8 busy=0", k, vout[0], busy[0]);
      end
    end
    vin[0] = 0.0;
    tick();
    // Two-cycle pulse is shorter than the fall delay and gets swallowed.
    eb = 8'b00000110;
    vin[0] = 1.8;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 1) vin[0] = 0.0;
      tests_run++;
      if (absd(vout[0], 1.8) > 1e-9 || dout[0] !== 1'b1 || busy[0] !== eb[k]) begin
        tests_failed++;
        $display("FAIL glitch k=%0d got vout=%f dout=%b busy=%b want vout=1.8 dout=1 busy=%b",
                 k, vout[0], dout[0], busy[0], eb[k]);
      end
    end
  endtask

  task automatic test_reversal;
    real        ev [9];
    logic [8:0] eb;
    ev = '{1.8, 1.8, 1.8, 1.8, 1.35, 0.9, 0.9, 1.35, 1.8};
    eb = 9'b011111110;
    vin[0] = 1.8;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 4) vin[0] = 0.0;
      tests_run++;
      if (absd(vout[0], ev[k]) > 1e-9 || dout[0] !== 1'b1 || busy[0] !== eb[k]) begin
        tests_failed++;
        $display("FAIL reversal k=%0d got vout=%f dout=%b busy=%b want vout=%f dout=1 busy=%b",
                 k, vout[0], dout[0], busy[0], ev[k], eb[k]);
      end
    end
  endtask

  task automatic test_enable;
    real        ev [9];
    real        e1 [7];
    logic [6:0] eb1;
    ev  = '{1.8, 1.8, 1.8, 1.8, 1.35, 0.9, 0.45, 0.0, 0.0};
    e1  = '{1.8, 1.8, 1.8, 1.35, 0.9, 0.45, 0.0};
    eb1 = 7'b0111111;
    en[1]  = 1'b0;
    vin[0] = 1.8;
    vin[1] = 1.8;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (absd(vout[0], ev[k]) > 1e-9) begin
        tests_failed++;
        $display("FAIL en_ch0 k=%0d got vout=%f want %f", k, vout[0], ev[k]);
      end
      tests_run++;
      if (absd(vout[1], 1.8) > 1e-9 || busy[1] !== 1'b0 || dout[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL en_frozen k=%0d got vout=%f busy=%b dout=%b want vout=1.8 busy=0 dout=1",
                 k, vout[1], busy[1], dout[1]);
      end
    end
    // Input level was tracked while disabled, so the edge starts on the first enabled cycle.
    en[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      tests_run++;
      if (absd(vout[1], e1[k]) > 1e-9 || busy[1] !== eb1[k]) begin
        tests_failed++;
        $display("FAIL en_resume k=%0d got vout=%f busy=%b want vout=%f busy=%b",
                 k, vout[1], busy[1], e1[k], eb1[k]);
      end
    end
    tests_run++;
    if (dout[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_resume_dout got %b want 0", dout[1]);
    end
    for (int c = 2; c < N; c++) begin
      tests_run++;
      if (absd(vout[c], 1.8) > 1e-9 || busy[c] !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_ch%0d got vout=%f busy=%b want vout=1.8 busy=0", c, vout[c], busy[c]);
      end
    end
  endtask

  task automatic test_reset_mid_ramp;
    vin[0] = 0.0;
    for (int k = 0; k < 4; k++) tick();
    tests_run++;
    if (absd(vout[0], 0.9) > 1e-9 || busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_rst got vout=%f busy=%b want vout=0.9 busy=1", vout[0], busy[0]);
    end
    rst = 1'b1;
    for (int c = 0; c < N; c++) vin[c] = 0.0;
    tick();
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (absd(vout[c], 1.8) > 1e-9 || dout[c] !== 1'b1 || busy[c] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_mid ch%0d got vout=%f dout=%b busy=%b want vout=1.8 dout=1 busy=0",
                 c, vout[c], dout[c], busy[c]);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (absd(vout[0], 1.8) > 1e-9 || busy[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_discard k=%0d got vout=%f busy=%b want vout=1.8 busy=0",
                 k, vout[0], busy[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = '1;
    for (int c = 0; c < N; c++) vin[c] = 0.0;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_reversal();
    test_enable();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
